// File: rtl/tomasulo_pkg.sv
// Shared widths, tag encoding and entry layout for the register status table.
// Imported by the interface, the per-register entry and the top level.
package tomasulo_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int TAG_W    = 5;
  localparam int NUM_REGS = 32;

  // All-ones tag: value present, no producer outstanding.
  localparam logic [TAG_W-1:0] INVALID_TAG = '1;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{value: '0, tag: INVALID_TAG};

  function automatic logic tag_live(input logic [TAG_W-1:0] t);
    return t != INVALID_TAG;
  endfunction

endpackage

// File: rtl/reg_status_table_if.sv
// Issue-side bundle of the register status table: read, rename, CDB, flush.
// master = issue stage / CDB driver, slave = the table.
interface reg_status_table_if;
  import tomasulo_pkg::*;

  logic              in_enable;
  logic [REG_W-1:0]  in_reg_1;
  logic [REG_W-1:0]  in_reg_2;
  logic              in_bank_enable;
  logic [REG_W-1:0]  in_bank_reg;
  logic [TAG_W-1:0]  in_bank_tag;
  logic              in_CDB_broadcast;
  logic [TAG_W-1:0]  in_CDB_tag;
  logic [DATA_W-1:0] in_CDB_val;
  logic              in_flush;
  logic              out_enable;
  logic [DATA_W-1:0] out_val_1;
  logic [DATA_W-1:0] out_val_2;
  logic [TAG_W-1:0]  out_tag_1;
  logic [TAG_W-1:0]  out_tag_2;

  modport master (
    output in_enable, in_reg_1, in_reg_2,
    output in_bank_enable, in_bank_reg,
    output in_bank_tag, in_CDB_broadcast,
    output in_CDB_tag, in_CDB_val, in_flush,
    input  out_enable, out_val_1, out_val_2,
    input  out_tag_1, out_tag_2
  );

  modport slave (
    input  in_enable, in_reg_1, in_reg_2,
    input  in_bank_enable, in_bank_reg,
    input  in_bank_tag, in_CDB_broadcast,
    input  in_CDB_tag, in_CDB_val, in_flush,
    output out_enable, out_val_1, out_val_2,
    output out_tag_1, out_tag_2
  );

endinterface

// File: rtl/reg_status_entry.sv
// One register's value/tag: rename, CDB capture and flush (READY/PENDING).
// Ports: clk, rst_n, ren_i/ren_tag_i, cdb_v_i/cdb_tag_i/cdb_val_i, flush_i, ent_o.
module reg_status_entry
  import tomasulo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren_i,
  input  logic [TAG_W-1:0]  ren_tag_i,
  input  logic              cdb_v_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  input  logic              flush_i,
  output entry_t            ent_o
);

  entry_t ent_q;
  entry_t ent_d;
  logic   hit;

  // cdb_v_i is never set with INVALID_TAG, so a READY entry cannot hit.
  always_comb begin
    ent_d = ent_q;
    hit   = cdb_v_i && (ent_q.tag == cdb_tag_i);
    if (hit) begin
      ent_d.value = cdb_val_i;
      ent_d.tag   = INVALID_TAG;
    end
    if (ren_i)   ent_d.tag = ren_tag_i;
    if (flush_i) ent_d.tag = INVALID_TAG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_q <= ENTRY_RST;
    else        ent_q <= ent_d;
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/reg_status_table.sv
// Register status table: per-register value+producer tag, 2 reads, rename, CDB.
// Ports: clk, rst_n, bus (reg_status_table_if.slave) carrying all requests/responses.
module reg_status_table
  import tomasulo_pkg::*;
#(
  parameter int NUM_REGS    = tomasulo_pkg::NUM_REGS,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_status_table_if.slave  bus
);

  entry_t ent [NUM_REGS];
  logic   cdb_v;
  logic   ren_ok;
  logic   fire;
  entry_t src1;
  entry_t src2;
  entry_t rd1;
  entry_t rd2;
  logic   oen_q;
  entry_t r1_q;
  entry_t r2_q;

  assign cdb_v  = bus.in_CDB_broadcast &&
                  tag_live(bus.in_CDB_tag);
  assign ren_ok = bus.in_bank_enable &&
                  tag_live(bus.in_bank_tag);
  assign fire   = bus.in_enable && !bus.in_flush;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
    if (ZERO_REG_EN && g == 0) begin : g_zero
      assign ent[g] = ENTRY_RST;
    end else begin : g_reg
      reg_status_entry u_ent (
        .clk       (clk),
        .rst_n     (rst_n),
        .ren_i     (ren_ok &&
                    bus.in_bank_reg == REG_W'(g)),
        .ren_tag_i (bus.in_bank_tag),
        .cdb_v_i   (cdb_v),
        .cdb_tag_i (bus.in_CDB_tag),
        .cdb_val_i (bus.in_CDB_val),
        .flush_i   (bus.in_flush),
        .ent_o     (ent[g])
      );
    end
  end

  assign src1 = ent[bus.in_reg_1];
  assign src2 = ent[bus.in_reg_2];

  // Bypass a result broadcast in the same cycle as the read.
  always_comb begin
    rd1 = src1;
    rd2 = src2;
    if (cdb_v && src1.tag == bus.in_CDB_tag)
      rd1 = '{value: bus.in_CDB_val, tag: INVALID_TAG};
    if (cdb_v && src2.tag == bus.in_CDB_tag)
      rd2 = '{value: bus.in_CDB_val, tag: INVALID_TAG};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oen_q <= 1'b0;
      r1_q  <= ENTRY_RST;
      r2_q  <= ENTRY_RST;
    end else begin
      oen_q <= fire;
      if (fire) begin
        r1_q <= rd1;
        r2_q <= rd2;
      end
    end
  end

  assign bus.out_enable = oen_q;
  assign bus.out_val_1  = r1_q.value;
  assign bus.out_tag_1  = r1_q.tag;
  assign bus.out_val_2  = r2_q.value;
  assign bus.out_tag_2  = r2_q.tag;

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_reg_status_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  reg_status_table_if bus ();

  reg_status_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] INV = 5'd31;

  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];
  logic        e_en;
  logic [31:0] e_v1, e_v2;
  logic [4:0]  e_t1, e_t2;

  task automatic idle();
    bus.in_enable        = 1'b0;
    bus.in_reg_1         = '0;
    bus.in_reg_2         = '0;
    bus.in_bank_enable   = 1'b0;
    bus.in_bank_reg      = '0;
    bus.in_bank_tag      = '0;
    bus.in_CDB_broadcast = 1'b0;
    bus.in_CDB_tag       = '0;
    bus.in_CDB_val       = '0;
    bus.in_flush         = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = INV;
    end
    e_en = 0;
    e_v1 = '0; e_v2 = '0;
    e_t1 = INV; e_t2 = INV;
  endtask

  // Resolve one source read against the pre-update table.
  task automatic look(input int r,
                      output logic [31:0] v,
                      output logic [4:0] t);
    logic cdb_ok;
    cdb_ok = bus.in_CDB_broadcast &&
             bus.in_CDB_tag != INV;
    if (r == 0) begin
      v = '0; t = INV;
    end else if (cdb_ok && m_tag[r] == bus.in_CDB_tag) begin
      v = bus.in_CDB_val; t = INV;
    end else begin
      v = m_val[r]; t = m_tag[r];
    end
  endtask

  // Predict the response, advance the model, clock once, idle inputs.
  task automatic tick();
    logic cdb_ok;
    int   br;
    cdb_ok = bus.in_CDB_broadcast &&
             bus.in_CDB_tag != INV;
    br = int'(bus.in_bank_reg);
    e_en = bus.in_enable && !bus.in_flush;
    if (e_en) begin
      look(int'(bus.in_reg_1), e_v1, e_t1);
      look(int'(bus.in_reg_2), e_v2, e_t2);
    end
    for (int i = 1; i < 32; i++)
      if (cdb_ok && m_tag[i] == bus.in_CDB_tag) begin
        m_val[i] = bus.in_CDB_val;
        m_tag[i] = INV;
      end
    if (bus.in_flush) begin
      for (int i = 0; i < 32; i++) m_tag[i] = INV;
    end else if (bus.in_bank_enable &&
                 bus.in_bank_tag != INV && br != 0) begin
      m_tag[br] = bus.in_bank_tag;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int a, input int b);
    bus.in_enable = 1'b1;
    bus.in_reg_1  = 5'(a);
    bus.in_reg_2  = 5'(b);
  endtask

  task automatic ren(input int r, input int t);
    bus.in_bank_enable = 1'b1;
    bus.in_bank_reg    = 5'(r);
    bus.in_bank_tag    = 5'(t);
  endtask

  task automatic cdb(input int t, input logic [31:0] v);
    bus.in_CDB_broadcast = 1'b1;
    bus.in_CDB_tag       = 5'(t);
    bus.in_CDB_val       = v;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.out_enable !== 1'b0 || bus.out_val_1 !== 0 ||
        bus.out_tag_1 !== INV || bus.out_tag_2 !== INV) begin
      bad++;
      $display("FAIL reset_out: en=%b v1=%h t1=%0d t2=%0d want 0/0/31/31",
               bus.out_enable, bus.out_val_1,
               bus.out_tag_1, bus.out_tag_2);
    end
    rd(1, 3);
    tick();
    total++;
    if (bus.out_enable !== 1'b1 || bus.out_val_1 !== 0 ||
        bus.out_val_2 !== 0 || bus.out_tag_1 !== INV ||
        bus.out_tag_2 !== INV) begin
      bad++;
      $display("FAIL reset_read: en=%b %h/%h %0d/%0d want 1 0/0 31/31",
               bus.out_enable, bus.out_val_1, bus.out_val_2,
               bus.out_tag_1, bus.out_tag_2);
    end
    tick();
    total++;
    if (bus.out_enable !== 1'b0) begin
      bad++;
      $display("FAIL one_shot: en=%b want 0", bus.out_enable);
    end
  endtask

  task automatic test_cdb_write();
    ren(8, 2);
    tick();
    cdb(2, 32'h8);
    tick();
    rd(8, 8);
    tick();
    total++;
    if (bus.out_val_1 !== 32'h8 || bus.out_tag_1 !== INV) begin
      bad++;
      $display("FAIL cdb_write: v=%h t=%0d want 8/31",
               bus.out_val_1, bus.out_tag_1);
    end
  endtask

  task automatic test_rename_read();
    ren(4, 7);
    rd(4, 4);
    tick();
    total++;
    if (bus.out_val_1 !== 0 || bus.out_tag_1 !== INV) begin
      bad++;
      $display("FAIL rename_old: v=%h t=%0d want 0/31",
               bus.out_val_1, bus.out_tag_1);
    end
    rd(4, 1);
    tick();
    total++;
    if (bus.out_tag_1 !== 5'd7) begin
      bad++;
      $display("FAIL rename_new: t=%0d want 7", bus.out_tag_1);
    end
  endtask

  task automatic test_bypass();
    ren(6, 3);
    tick();
    rd(1, 6);
    cdb(3, 32'h55);
    tick();
    total++;
    if (bus.out_val_2 !== 32'h55 || bus.out_tag_2 !== INV) begin
      bad++;
      $display("FAIL bypass: v=%h t=%0d want 55/31",
               bus.out_val_2, bus.out_tag_2);
    end
  endtask

  task automatic test_stale();
    logic [31:0] old;
    old = m_val[9];
    ren(9, 4);
    tick();
    ren(9, 5);
    tick();
    cdb(4, 32'h11);
    tick();
    rd(9, 9);
    tick();
    total++;
    if (bus.out_val_1 !== old || bus.out_tag_1 !== 5'd5) begin
      bad++;
      $display("FAIL stale_cdb: v=%h t=%0d want %h/5",
               bus.out_val_1, bus.out_tag_1, old);
    end
  endtask

  task automatic test_same_reg();
    ren(12, 9);
    tick();
    ren(12, 10);
    cdb(9, 32'hABCD);
    tick();
    rd(12, 0);
    tick();
    total++;
    if (bus.out_val_1 !== 32'hABCD || bus.out_tag_1 !== 5'd10) begin
      bad++;
      $display("FAIL ren_cdb_same: v=%h t=%0d want abcd/10",
               bus.out_val_1, bus.out_tag_1);
    end
  endtask

  task automatic test_flush();
    logic [31:0] hv;
    ren(2, 8);
    tick();
    ren(7, 9);
    rd(3, 3);
    tick();
    hv = bus.out_val_1;
    bus.in_flush = 1'b1;
    ren(10, 1);
    rd(2, 7);
    cdb(9, 32'h77);
    tick();
    total++;
    if (bus.out_enable !== 1'b0 || bus.out_val_1 !== hv) begin
      bad++;
      $display("FAIL flush_noresp: en=%b v=%h want 0/%h",
               bus.out_enable, bus.out_val_1, hv);
    end
    rd(2, 7);
    tick();
    total++;
    if (bus.out_tag_1 !== INV || bus.out_tag_2 !== INV ||
        bus.out_val_2 !== 32'h77) begin
      bad++;
      $display("FAIL flush_tags: t=%0d/%0d v2=%h want 31/31/77",
               bus.out_tag_1, bus.out_tag_2, bus.out_val_2);
    end
    rd(10, 10);
    tick();
    total++;
    if (bus.out_tag_1 !== INV) begin
      bad++;
      $display("FAIL flush_ren: t=%0d want 31", bus.out_tag_1);
    end
  endtask

  task automatic test_zero_last();
    ren(0, 6);
    tick();
    cdb(31, 32'h1);
    ren(31, 12);
    tick();
    cdb(12, 32'hBEEF);
    tick();
    rd(0, 31);
    tick();
    total++;
    if (bus.out_val_1 !== 0 || bus.out_tag_1 !== INV ||
        bus.out_val_2 !== 32'hBEEF || bus.out_tag_2 !== INV) begin
      bad++;
      $display("FAIL zero_last: %h/%0d %h/%0d want 0/31 beef/31",
               bus.out_val_1, bus.out_tag_1,
               bus.out_val_2, bus.out_tag_2);
    end
  endtask

  task automatic test_reset_mid();
    ren(5, 2);
    tick();
    cdb(2, 32'hCAFE);
    tick();
    rd(5, 5);
    tick();
    total++;
    if (bus.out_val_1 !== 32'hCAFE || bus.out_enable !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: v=%h en=%b want cafe/1",
               bus.out_val_1, bus.out_enable);
    end
    rd(5, 5);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_enable !== 1'b0 || bus.out_val_1 !== 0) begin
      bad++;
      $display("FAIL async_reset: en=%b v=%h want 0/0",
               bus.out_enable, bus.out_val_1);
    end
    do_reset();
    rd(5, 5);
    tick();
    total++;
    if (bus.out_val_1 !== 0 || bus.out_tag_1 !== INV) begin
      bad++;
      $display("FAIL post_reset: v=%h t=%0d want 0/31",
               bus.out_val_1, bus.out_tag_1);
    end
  endtask

  task automatic test_random();
    int nerr = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_enable = 1'($urandom_range(0, 2) != 0);
      bus.in_reg_1  = 5'($urandom);
      bus.in_reg_2  = 5'($urandom);
      if ($urandom_range(0, 2) == 0)
        ren($urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 3) != 0)
          cdb(int'(m_tag[$urandom_range(0, 31)]), $urandom);
        else
          cdb($urandom_range(0, 31), $urandom);
      end
      bus.in_flush = 1'($urandom_range(0, 40) == 0);
      tick();
      total++;
      if (bus.out_enable !== e_en ||
          bus.out_val_1 !== e_v1 || bus.out_tag_1 !== e_t1 ||
          bus.out_val_2 !== e_v2 || bus.out_tag_2 !== e_t2) begin
        bad++;
        nerr++;
        if (nerr < 10)
          $display("FAIL rand[%0d]: %b %h/%0d %h/%0d want %b %h/%0d %h/%0d",
                   c, bus.out_enable, bus.out_val_1, bus.out_tag_1,
                   bus.out_val_2, bus.out_tag_2, e_en,
                   e_v1, e_t1, e_v2, e_t2);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_cdb_write();
    test_rename_read();
    test_bypass();
    test_stale();
    test_same_reg();
    test_flush();
    test_zero_last();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
